// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit MEM-stage accesses into two 16-bit SRAM half-word transactions, low half first.
//   clk, rst (async active-low) | rd_en, wr_en, address, write_data from the pipeline
//   read_data (registered word), ready (0 = freeze pipeline) | SRAM_DQ, SRAM_ADDR, SRAM_WE_N to the SRAM pins
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic wr_op;
  logic [31:0] off;
  logic phase, last;
  assign off = address - BASE_ADDR;
  assign phase = state == LO || state == HI;
  assign last = cnt == LAST;
  assign SRAM_ADDR = phase ? {off[18:2], state == HI} : '0;
  // WE_N rises on the final phase cycle while address and data are still held
  assign SRAM_WE_N = !(phase && wr_op && !last);
  assign SRAM_DQ = (phase && wr_op) ? (state == HI ? write_data[31:16] : write_data[15:0]) : 'z;
  assign ready = state == DONE || (state == IDLE && !rd_en && !wr_en);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      wr_op <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: if (rd_en || wr_en) begin
          wr_op <= wr_en;
          cnt <= '0;
          state <= LO;
        end
        LO, HI: if (last) begin
          cnt <= '0;
          state <= state == LO ? HI : DONE;
          if (!wr_op && state == LO) read_data[15:0] <= SRAM_DQ;
          if (!wr_op && state == HI) read_data[31:16] <= SRAM_DQ;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller against a 16-entry half-word SRAM model.
module tb_sram_controller;
  logic clk = 0, rst = 0, rd_en = 0, wr_en = 0;
  logic [31:0] address = 0, write_data = 0;
  wire [31:0] read_data;
  wire ready;
  wire [15:0] SRAM_DQ;
  wire [17:0] SRAM_ADDR;
  wire SRAM_WE_N;
  logic [15:0] mem [16];
  logic [3:0] wa;
  logic [15:0] wd;
  int vectors = 0, miscompares = 0, bad_rise = 0;
  always #5 clk = ~clk;
  sram_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N)
  );
  assign SRAM_DQ = (rd_en && !wr_en && SRAM_WE_N) ? mem[SRAM_ADDR[3:0]] : 'z;
  always @(posedge clk) if (SRAM_WE_N === 1'b0) begin
    mem[SRAM_ADDR[3:0]] <= SRAM_DQ;
    wa <= SRAM_ADDR[3:0];
    wd <= SRAM_DQ;
  end
  always @(posedge SRAM_WE_N) if (rst && (SRAM_ADDR[3:0] !== wa || SRAM_DQ !== wd)) bad_rise++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input string tag);
    int lows = 0;
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    if (ready) @(negedge clk);
    while (!ready && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    check({tag, "_low_cycles"}, lows, 5);
    check({tag, "_done_ready"}, ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_we_n", SRAM_WE_N, 1);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_dq_z", SRAM_DQ === 16'hzzzz, 1);
    check("rst_rdata", read_data, 0);
    rst = 1;
    repeat (10) begin
      @(negedge clk);
      check("idle", {ready, SRAM_WE_N, SRAM_DQ === 16'hzzzz, read_data == 32'h0}, 4'hf);
    end
    access(1, 0, 1024, 32'h12345678, "wr1");
    wr_en = 0;
    @(negedge clk);
    check("wr1_mem0", mem[0], 16'h5678);
    check("wr1_mem1", mem[1], 16'h1234);
    access(0, 1, 1024, 0, "rd1");
    check("rd1_data", read_data, 32'h12345678);
    rd_en = 0;
    @(negedge clk);
    check("rd1_hold", read_data, 32'h12345678);
    access(1, 0, 1028, 32'hCAFEBABE, "b2b1");
    check("b2b1_mem2", mem[2], 16'hBABE);
    check("b2b1_mem3", mem[3], 16'hCAFE);
    access(1, 0, 1030, 32'h0BADF00D, "b2b2");
    wr_en = 0;
    @(negedge clk);
    check("b2b2_mem2", mem[2], 16'hF00D);
    check("b2b2_mem3", mem[3], 16'h0BAD);
    access(0, 1, 1028, 0, "rd2");
    check("rd2_data", read_data, 32'h0BADF00D);
    rd_en = 0;
    @(negedge clk);
    access(1, 1, 1032, 32'hA5A55A5A, "prio");
    check("prio_rdata", read_data, 32'h0BADF00D);
    wr_en = 0; rd_en = 0;
    @(negedge clk);
    check("prio_mem4", mem[4], 16'h5A5A);
    check("prio_mem5", mem[5], 16'hA5A5);
    wr_en = 1; address = 1024; write_data = 32'hFFFF0000;
    repeat (3) @(negedge clk);
    check("hi_phase_we_n", SRAM_WE_N, 0);
    check("hi_phase_addr", SRAM_ADDR, 1);
    #1;
    rst = 0; wr_en = 0;
    #1;
    check("abort_we_n", SRAM_WE_N, 1);
    check("abort_dq_z", SRAM_DQ === 16'hzzzz, 1);
    check("abort_ready", ready, 1);
    check("abort_rdata", read_data, 0);
    @(negedge clk);
    check("abort_mem0", mem[0], 16'h0000);
    check("abort_mem1", mem[1], 16'h1234);
    rst = 1;
    @(negedge clk);
    access(0, 1, 1024, 0, "rd3");
    check("rd3_data", read_data, 32'h12340000);
    rd_en = 0;
    @(negedge clk);
    check("we_rise_stable", bad_rise, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit data-memory accesses from the MEM stage onto the 16-bit external SRAM as two half-word transactions, low half first. It sits between the MEM stage and the SRAM pins. It drives `ready` low to freeze the pipeline until the full word has been transferred.

## Interface
- `BASE_ADDR`, default 1024: CPU byte address that maps to SRAM half-word 0.
- `WAIT_CYCLES`, default 1, minimum 1: extra cycles added to each half-word phase.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `rd_en`  in  1: read request; held by the pipeline until `ready` is sampled high.
- `wr_en`  in  1: write request; same holding rule. If both requests are high, the write wins.
- `address`  in  32: CPU byte address (ALU result).
- `write_data`  in  32: word to store (Val_Rm).
- `read_data`  out  32: last word read; registered.
- `ready`  out  1: 0 means freeze the pipeline; 1 means the access is complete or the block is idle.
- `SRAM_DQ`  inout  16: SRAM data bus.
- `SRAM_ADDR`  out  18: SRAM half-word address.
- `SRAM_WE_N`  out  1: SRAM write enable, active-low.

## Operation
- Address mapping: `off = address - BASE_ADDR` (32-bit, wraps modulo 2^32); `widx = off[18:2]`.
  - Low half: `SRAM_ADDR = {widx, 1'b0}`.
  - High half: `SRAM_ADDR = {widx, 1'b1}`.
  - `address[1:0]` is ignored.
- FSM states: IDLE, LO, HI, DONE. A phase counter `cnt` counts 0..WAIT_CYCLES.
- IDLE
  - No request: stay in IDLE, `ready = 1`.
  - Request: latch the operation (write wins), go to LO with `cnt = 0`, `ready = 0` (combinational from the request).
- LO
  - Hold `SRAM_ADDR = {widx, 0}`.
  - Write: drive `SRAM_DQ = write_data[15:0]`. `SRAM_WE_N = 0` for cnt < WAIT_CYCLES and 1 on the last phase cycle, so address and data stay stable across the WE_N rising edge.
  - Read: `SRAM_DQ` is high-Z, `SRAM_WE_N = 1`. Capture `SRAM_DQ` into the low half of `read_data` on the edge leaving the last phase cycle.
  - At cnt == WAIT_CYCLES, go to HI with `cnt = 0`.
- HI: same rules with `{widx, 1}`, `write_data[31:16]` and the `read_data[31:16]` half. At cnt == WAIT_CYCLES, go to DONE.
- DONE
  - `ready = 1` for exactly one cycle, so the pipeline advances on that edge.
  - Go to IDLE unconditionally.
  - The request still held during DONE is not restarted.
- `SRAM_DQ` is driven only in write LO/HI cycles; it is high-Z everywhere else.
- `read_data` updates only during reads; writes leave it unchanged.
- `address` and `write_data` are used combinationally. They must stay stable while `ready = 0`; the pipeline freeze guarantees this.

## Timing
- Reset values (asynchronous, while `rst = 0`):
  - state IDLE, `cnt = 0`.
  - `read_data = 0`.
  - `SRAM_WE_N = 1`, `SRAM_ADDR = 0`, `SRAM_DQ` high-Z.
  - `ready = 1` (no request assumed).
- Reset mid-access:
  - The access is aborted immediately and the state returns to IDLE.
  - A partial write may leave the low half written and the high half unwritten.
  - A partially captured `read_data` is cleared to 0.
- Access length, from the first cycle the request is seen in IDLE:
  - `ready` is low for `1 + 2*(WAIT_CYCLES+1)` cycles, i.e. 5 cycles with the default.
  - `ready` is high in the next cycle (DONE).
  - Total is `2*(WAIT_CYCLES+1) + 2` cycles per access.
- Back-to-back requests:
  - The next request is seen in the IDLE cycle immediately after DONE.
  - There is no extra gap beyond that IDLE cycle, which itself has `ready = 0`.
- Addresses below `BASE_ADDR` or beyond 2^19 bytes wrap by truncation to 17 index bits; no error is flagged.
- A request dropped while in LO/HI is still completed; the FSM does not sample the request after IDLE.

## Test plan
- Idle check: `rd_en = wr_en = 0` for 10 cycles after reset -> `ready = 1`, `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, `read_data = 0` throughout.
- Single write: `wr_en = 1`, `address = 1024`, `write_data = 0x12345678` ->
  - `ready` low for 5 cycles, then high for 1 cycle.
  - SRAM model holds 0x5678 at address 0 and 0x1234 at address 1.
  - `SRAM_WE_N` rises while address and data are stable.
- Readback: `rd_en = 1`, `address = 1024` after the write -> `read_data = 0x12345678` in the DONE cycle with `ready = 1`; the value is held afterwards.
- Mapping and back-to-back:
  - Write 0xCAFEBABE to 1028, then immediately write 0x0BADF00D to 1030.
  - Required: both land at SRAM addresses 2/3, the second overwrites the first, and each access takes 6 cycles.
  - Reading back 1028 returns 0x0BADF00D.
- Priority: `rd_en = wr_en = 1`, `address = 1032`, `write_data = 0xA5A5_5A5A` -> a write is performed (SRAM 4/5 = 0x5A5A/0xA5A5) and `read_data` is unchanged.
- Reset mid-write:
  - Drop `rst` during the HI phase of a write of 0xFFFF0000 to 1024 (SRAM initially 0x12345678).
  - Required: `SRAM_WE_N = 1`, `SRAM_DQ` high-Z and `ready = 1` immediately. SRAM address 0 = 0x0000, address 1 = 0x1234.
  - After release, a fresh access completes normally.
